// File: rtl/step_dir_monitor_if.sv
// Step/dir/enable monitor bus: raw driver pins and control strobes in,
// reconstructed position, period and error flags out.
interface step_dir_monitor_if #(
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 24
);
    logic                    step_in;
    logic                    dir_in;
    logic                    enable_in;
    logic                    pos_load;
    logic [POS_WIDTH-1:0]    pos_load_value;
    logic                    clear;
    logic                    err_clear;
    logic [POS_WIDTH-1:0]    position;
    logic                    step_strobe;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    err_setup;
    logic                    err_pulse;
    logic                    err_disabled;

    modport master (
        output step_in, dir_in, enable_in, pos_load, pos_load_value, clear, err_clear,
        input  position, step_strobe, period, period_valid, err_setup, err_pulse, err_disabled
    );

    modport slave (
        input  step_in, dir_in, enable_in, pos_load, pos_load_value, clear, err_clear,
        output position, step_strobe, period, period_valid, err_setup, err_pulse, err_disabled
    );
endinterface

// File: rtl/step_dir_monitor.sv
// Step/dir/enable receiver: synchronizes the raw pins, tracks signed position,
// measures step period and flags dir-setup, pulse-width and disabled-step violations.
module step_dir_monitor #(
    parameter int POS_WIDTH        = 32,
    parameter int PERIOD_WIDTH     = 24,
    parameter int SYNC_STAGES      = 2,
    parameter int DIR_SETUP_CYCLES = 10,
    parameter int MIN_PULSE_CYCLES = 50
) (
    input logic               clk,
    input logic               rst,
    step_dir_monitor_if.slave bus
);
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam int DIR_W = $clog2(DIR_SETUP_CYCLES + 1);
    localparam int HI_W  = $clog2(MIN_PULSE_CYCLES + 1);

    typedef enum logic [1:0] {S_ARM, S_LOW, S_HIGH} state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  step_sync, dir_sync, en_sync;
    logic                    s_step, s_dir, s_en;
    logic [ARM_W-1:0]        arm_cnt;
    logic                    arm_done;
    logic                    dir_prev;
    logic [DIR_W-1:0]        dir_cnt;
    logic [HI_W-1:0]         hi_cnt;
    logic [PERIOD_WIDTH-1:0] per_cnt;
    logic                    first_seen;
    logic [POS_WIDTH-1:0]    position_q;
    logic                    strobe_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    period_valid_q;
    logic                    err_setup_q, err_pulse_q, err_disabled_q;

    logic                    step_event, pulse_end, dir_change, setup_bad;
    logic                    count_apply;
    logic [POS_WIDTH-1:0]    step_delta;

    assign s_step   = step_sync[SYNC_STAGES-1];
    assign s_dir    = dir_sync[SYNC_STAGES-1];
    assign s_en     = en_sync[SYNC_STAGES-1];
    // The chain comes out of reset at 0, so arming waits until it holds real
    // samples; otherwise a step held high through reset would look like an edge.
    assign arm_done = (arm_cnt == ARM_W'(SYNC_STAGES));

    always_comb begin
        state_next  = state;
        step_event  = 1'b0;
        pulse_end   = 1'b0;
        case (state)
            S_ARM:   if (arm_done && !s_step) state_next = S_LOW;
            S_LOW:   if (s_step) begin
                         state_next = S_HIGH;
                         step_event = 1'b1;
                     end
            S_HIGH:  if (!s_step) begin
                         state_next = S_LOW;
                         pulse_end  = 1'b1;
                     end
            default: state_next = S_ARM;
        endcase
        dir_change  = (s_dir != dir_prev);
        setup_bad   = dir_change || (dir_cnt < DIR_W'(DIR_SETUP_CYCLES));
        count_apply = step_event && !s_en && !bus.pos_load && !bus.clear;
        step_delta  = s_dir ? POS_WIDTH'(1) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_ARM;
            step_sync      <= '0;
            dir_sync       <= '0;
            en_sync        <= '1;
            arm_cnt        <= '0;
            dir_prev       <= 1'b0;
            dir_cnt        <= '0;
            hi_cnt         <= '0;
            per_cnt        <= '0;
            first_seen     <= 1'b0;
            position_q     <= '0;
            strobe_q       <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            err_setup_q    <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_disabled_q <= 1'b0;
        end else begin
            state     <= state_next;
            step_sync <= {step_sync[SYNC_STAGES-2:0], bus.step_in};
            dir_sync  <= {dir_sync[SYNC_STAGES-2:0], bus.dir_in};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], bus.enable_in};
            if (!arm_done) arm_cnt <= arm_cnt + ARM_W'(1);

            dir_prev <= s_dir;
            if (dir_change)
                dir_cnt <= '0;
            else if (dir_cnt != DIR_W'(DIR_SETUP_CYCLES))
                dir_cnt <= dir_cnt + DIR_W'(1);

            if (step_event)
                hi_cnt <= HI_W'(1);
            else if (state == S_HIGH && hi_cnt != HI_W'(MIN_PULSE_CYCLES))
                hi_cnt <= hi_cnt + HI_W'(1);

            if (bus.pos_load)
                position_q <= bus.pos_load_value;
            else if (bus.clear)
                position_q <= '0;
            else if (count_apply)
                position_q <= position_q + step_delta;
            strobe_q <= count_apply;

            if (bus.clear) begin
                per_cnt        <= '0;
                first_seen     <= 1'b0;
                period_valid_q <= 1'b0;
            end else if (count_apply) begin
                per_cnt    <= PERIOD_WIDTH'(1);
                period_q   <= per_cnt;
                first_seen <= 1'b1;
                if (first_seen) period_valid_q <= 1'b1;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + PERIOD_WIDTH'(1);
            end

            err_setup_q    <= (step_event && setup_bad) || (err_setup_q && !bus.err_clear);
            err_pulse_q    <= (pulse_end && hi_cnt < HI_W'(MIN_PULSE_CYCLES))
                              || (err_pulse_q && !bus.err_clear);
            err_disabled_q <= (step_event && s_en) || (err_disabled_q && !bus.err_clear);
        end
    end

    assign bus.position     = position_q;
    assign bus.step_strobe  = strobe_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.err_setup    = err_setup_q;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.err_disabled = err_disabled_q;
endmodule

// File: tb/tb_step_dir_monitor.sv
// Bench for step_dir_monitor: directed pulse trains checked every cycle against an
// event-level model of the raw pin stream, plus hand-computed literal checkpoints.
module tb_step_dir_monitor;
    localparam int POS_W  = 32;
    localparam int PER_W  = 24;
    localparam int SYNC   = 2;
    localparam int SETUP  = 10;
    localparam int MINP   = 50;
    localparam int PERMAX = (1 << PER_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   strobe_cnt = 0;

    step_dir_monitor_if #(.POS_WIDTH(POS_W), .PERIOD_WIDTH(PER_W)) bus ();

    step_dir_monitor #(
        .POS_WIDTH(POS_W), .PERIOD_WIDTH(PER_W), .SYNC_STAGES(SYNC),
        .DIR_SETUP_CYCLES(SETUP), .MIN_PULSE_CYCLES(MINP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each raw sample is classified (rise, fall, dir age) and its effect
    // lands SYNC_STAGES samples later; control strobes act on the edge they are seen.
    typedef struct {
        logic ev;
        logic en;
        logic dir;
        logic setup;
        logic perr;
        int   idx;
    } eff_t;

    eff_t        effq[$];
    eff_t        e, d;
    logic        have_d;
    int          n, j0, rise_idx, last_idx;
    logic        have_prev, prev_step, prev_dir, in_pulse, last_ok;
    logic [31:0] exp_pos;
    logic [23:0] exp_period;
    logic        exp_strobe, exp_valid, exp_es, exp_ep, exp_ed;

    always @(posedge clk) begin
        if (rst) begin
            effq.delete();
            n = 0; j0 = -1; rise_idx = 0; last_idx = 0;
            have_prev = 0; prev_step = 0; prev_dir = 0; in_pulse = 0; last_ok = 0;
            exp_pos = '0; exp_period = '0; exp_strobe = 0; exp_valid = 0;
            exp_es = 0; exp_ep = 0; exp_ed = 0;
        end else begin
            n++;
            e = '{ev: 1'b0, en: bus.enable_in, dir: bus.dir_in, setup: 1'b0, perr: 1'b0, idx: n};
            if (bus.dir_in != prev_dir) j0 = n;
            e.ev    = have_prev && !prev_step && bus.step_in;
            e.setup = (n - j0) <= SETUP;
            if (in_pulse && !bus.step_in) begin
                e.perr   = (n - rise_idx) < MINP;
                in_pulse = 0;
            end
            if (e.ev) begin
                in_pulse = 1;
                rise_idx = n;
            end
            prev_step = bus.step_in;
            prev_dir  = bus.dir_in;
            have_prev = 1;
            effq.push_back(e);

            have_d = 0;
            d = '{ev: 1'b0, en: 1'b0, dir: 1'b0, setup: 1'b0, perr: 1'b0, idx: 0};
            if (effq.size() > SYNC) begin
                d = effq.pop_front();
                have_d = 1;
            end
            exp_strobe = have_d && d.ev && !d.en && !bus.pos_load && !bus.clear;
            if (bus.pos_load)   exp_pos = bus.pos_load_value;
            else if (bus.clear) exp_pos = '0;
            else if (exp_strobe) exp_pos = exp_pos + (d.dir ? 32'd1 : 32'hFFFF_FFFF);

            exp_es = (have_d && d.ev && d.setup) || (exp_es && !bus.err_clear);
            exp_ep = (have_d && d.perr)          || (exp_ep && !bus.err_clear);
            exp_ed = (have_d && d.ev && d.en)    || (exp_ed && !bus.err_clear);

            if (bus.clear) begin
                exp_valid = 0;
                last_ok   = 0;
            end else if (exp_strobe) begin
                if (last_ok) begin
                    exp_period = ((d.idx - last_idx) > PERMAX) ? 24'(PERMAX) : 24'(d.idx - last_idx);
                    exp_valid  = 1;
                end
                last_ok  = 1;
                last_idx = d.idx;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("position", bus.position, exp_pos);
            check("step_strobe", bus.step_strobe, exp_strobe);
            check("period_valid", bus.period_valid, exp_valid);
            check("err_setup", bus.err_setup, exp_es);
            check("err_pulse", bus.err_pulse, exp_ep);
            check("err_disabled", bus.err_disabled, exp_ed);
            if (exp_valid) check("period", bus.period, exp_period);
            if (bus.step_strobe === 1'b1) strobe_cnt++;
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic step_pulse(input int high, input int low);
        bus.step_in = 1'b1;
        tick(high);
        bus.step_in = 1'b0;
        tick(low);
    endtask

    task automatic pulse_err_clear();
        bus.err_clear = 1'b1;
        tick(1);
        bus.err_clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_position"}, bus.position, 0);
        check({tag, "_strobe"}, bus.step_strobe, 0);
        check({tag, "_period"}, bus.period, 0);
        check({tag, "_valid"}, bus.period_valid, 0);
        check({tag, "_errs"}, {bus.err_setup, bus.err_pulse, bus.err_disabled}, 0);
    endtask

    int snap;

    initial begin
        rst = 1'b1;
        bus.step_in = 1'b0; bus.dir_in = 1'b1; bus.enable_in = 1'b0;
        bus.pos_load = 1'b0; bus.pos_load_value = '0; bus.clear = 1'b0; bus.err_clear = 1'b0;
        #3;
        check_reset_outputs("reset");
        tick(2);
        rst = 1'b0;
        tick(20);

        // 1: five forward steps, 100 high / 1000 period
        snap = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            step_pulse(100, 900);
            if (i == 0) begin
                check("t1_pos_first", bus.position, 1);
                check("t1_valid_first", bus.period_valid, 0);
            end
        end
        check("t1_pos", bus.position, 5);
        check("t1_strobes", strobe_cnt - snap, 5);
        check("t1_period", bus.period, 1000);
        check("t1_valid", bus.period_valid, 1);
        check("t1_errs", {bus.err_setup, bus.err_pulse, bus.err_disabled}, 0);

        // 2: clear, then dir flips 3 cycles before the rise (also 0 - 1 wrap)
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        check("t2_clear_pos", bus.position, 0);
        check("t2_clear_valid", bus.period_valid, 0);
        bus.dir_in = 1'b0;
        tick(3);
        step_pulse(100, 900);
        check("t2_pos_wrap", bus.position, 32'hFFFF_FFFF);
        check("t2_err_setup", bus.err_setup, 1);
        pulse_err_clear();
        check("t2_err_setup_clr", bus.err_setup, 0);

        // 3: pulse-width boundary around MIN_PULSE_CYCLES
        bus.dir_in = 1'b1;
        tick(50);
        step_pulse(20, 500);
        check("t3_pos_20", bus.position, 0);
        check("t3_err_20", bus.err_pulse, 1);
        pulse_err_clear();
        step_pulse(49, 500);
        check("t3_err_49", bus.err_pulse, 1);
        pulse_err_clear();
        step_pulse(50, 500);
        check("t3_err_50", bus.err_pulse, 0);
        check("t3_pos_50", bus.position, 2);

        // 4: driver disabled
        bus.enable_in = 1'b1;
        tick(5);
        snap = strobe_cnt;
        for (int i = 0; i < 3; i++) step_pulse(100, 200);
        check("t4_pos", bus.position, 2);
        check("t4_strobes", strobe_cnt - snap, 0);
        check("t4_err_dis", bus.err_disabled, 1);
        bus.enable_in = 1'b0;
        tick(5);
        pulse_err_clear();
        check("t4_err_dis_clr", bus.err_disabled, 0);

        // 5: load at positive limit, wrap, then a load colliding with a step update
        bus.pos_load = 1'b1; bus.pos_load_value = 32'h7FFF_FFFF;
        tick(1);
        bus.pos_load = 1'b0;
        check("t5_load", bus.position, 32'h7FFF_FFFF);
        step_pulse(100, 500);
        check("t5_wrap", bus.position, 32'h8000_0000);
        snap = strobe_cnt;
        bus.step_in = 1'b1;
        tick(SYNC);
        bus.pos_load = 1'b1; bus.pos_load_value = 32'h10;
        tick(1);
        bus.pos_load = 1'b0;
        check("t5_coinc_pos", bus.position, 32'h10);
        tick(97);
        bus.step_in = 1'b0;
        tick(200);
        check("t5_coinc_pos_late", bus.position, 32'h10);
        check("t5_coinc_strobes", strobe_cnt - snap, 0);

        // 6: reset while step held high, released still high
        bus.step_in = 1'b1;
        tick(10);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick(3);
        rst = 1'b0;
        snap = strobe_cnt;
        tick(30);
        check("t6_held_pos", bus.position, 0);
        check("t6_held_strobes", strobe_cnt - snap, 0);
        bus.step_in = 1'b0;
        tick(50);
        step_pulse(100, 100);
        check("t6_pos", bus.position, 1);
        check("t6_strobes", strobe_cnt - snap, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
